rr_mem_arbiter: RTL and testbench

- Round-robin arbiter sharing one memory request port among N requestors; each requestor is a valid/ready channel.
- Sits between the requestor vector and the single memory port.
- Accepted requests are registered in a one-entry output buffer: one cycle of latency, back-to-back throughput.
- Grants rotate so no requestor starves while others are persistently valid.

---
 rtl/rr_mem_arbiter.sv | 78 +++++++
 tb/tb_rr_mem_arbiter.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/rr_mem_arbiter.sv
// rr_mem_arbiter: round-robin arbiter of N valid/ready requestors onto one buffered memory port.
// Define RR_MEM_ARBITER_GRANT_CNT_EN to add a saturating 16-bit grant counter output.
module rr_mem_arbiter #(
    parameter int N      = 4,
    parameter int DATA_W = 32,
    parameter int ID_W   = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N-1:0]        req_valid,
    input  logic [N*DATA_W-1:0] req_bits,
    output logic [N-1:0]        req_ready,
    output logic                mem_valid,
    input  logic                mem_ready,
    output logic [DATA_W-1:0]   mem_bits,
    output logic [ID_W-1:0]     mem_id,
`ifdef RR_MEM_ARBITER_GRANT_CNT_EN
    output logic [15:0]         grant_cnt,
`endif
    output logic                busy
);
    logic              full_q, full_d;
    logic [ID_W-1:0]   ptr_q, ptr_d, id_q, win;
    logic [DATA_W-1:0] bits_q;
    logic [N-1:0]      rot;
    logic              found, accept;
    int                off, sum;

    // rotate so bit 0 is the requestor at ptr; lowest set bit is the winner's offset
    assign rot = N'({req_valid, req_valid} >> ptr_q);

    always_comb begin
        off   = 0;
        found = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off   = k;
                found = 1'b1;
            end
        end
        sum    = int'(ptr_q) + off;
        win    = ID_W'(sum >= N ? sum - N : sum);
        accept = found && (!full_q || mem_ready);
        ptr_d  = accept ? ID_W'(int'(win) == N - 1 ? 0 : int'(win) + 1) : ptr_q;
        full_d = accept || (full_q && !mem_ready);
    end

    assign req_ready = accept ? (N'(1) << win) : '0;
    assign mem_valid = full_q;
    assign busy      = full_q;
    assign mem_bits  = bits_q;
    assign mem_id    = id_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full_q <= 1'b0;
            ptr_q  <= '0;
            bits_q <= '0;
            id_q   <= '0;
        end else begin
            full_q <= full_d;
            ptr_q  <= ptr_d;
            if (accept) begin
                bits_q <= req_bits[int'(win)*DATA_W +: DATA_W];
                id_q   <= win;
            end
        end
    end

`ifdef RR_MEM_ARBITER_GRANT_CNT_EN
    logic [15:0] cnt_q;
    assign grant_cnt = cnt_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else if (accept && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
    end
`endif
endmodule

// File: tb/tb_rr_mem_arbiter.sv
// tb_rr_mem_arbiter: scoreboard bench with a scan-order reference model of the arbiter.
module tb_rr_mem_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int IW = 2;

    logic          clk = 0, reset = 1;
    logic [N-1:0]  req_valid = '0;
    logic [N*DW-1:0] req_bits = '0;
    logic          mem_ready = 0;
    logic [N-1:0]  req_ready;
    logic          mem_valid, busy;
    logic [DW-1:0] mem_bits;
    logic [IW-1:0] mem_id;
`ifdef RR_MEM_ARBITER_GRANT_CNT_EN
    logic [15:0]   grant_cnt;
`endif

    rr_mem_arbiter #(.N(N), .DATA_W(DW), .ID_W(IW)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_bits(req_bits),
        .req_ready(req_ready), .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_bits(mem_bits), .mem_id(mem_id),
`ifdef RR_MEM_ARBITER_GRANT_CNT_EN
        .grant_cnt(grant_cnt),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { int id; logic [DW-1:0] bits; } item_t;
    item_t q[$];
    int checks = 0, passed = 0;
    int m_ptr = 0, m_cnt = 0;
    bit m_full = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // reference model: grant the first valid requestor in scan order from ptr
    always @(negedge clk) begin
        #1;
        if (!reset) begin : model
            int w;
            bit can;
            logic [N-1:0] exp_rdy;
            w = -1;
            exp_rdy = '0;
            can = !m_full || mem_ready;
            for (int k = 0; k < N; k++)
                if (w < 0 && req_valid[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            if (w >= 0 && can) exp_rdy[w] = 1'b1;
            check("req_ready", 64'(req_ready), 64'(exp_rdy));
            if (w >= 0 && can) begin
                q.push_back('{w, req_bits[w*DW +: DW]});
                m_ptr = (w + 1) % N;
                m_full = 1;
                if (m_cnt < 65535) m_cnt++;
            end else if (mem_ready) m_full = 0;
        end
    end

    // monitor: compare the presented buffer against the scoreboard front
    always @(negedge clk) begin
        check("mem_valid", 64'(mem_valid), 64'(q.size() != 0));
        check("busy", 64'(busy), 64'(q.size() != 0));
        if (q.size() != 0) begin
            check("mem_id", 64'(mem_id), 64'(q[0].id));
            check("mem_bits", 64'(mem_bits), 64'(q[0].bits));
            if (mem_ready) void'(q.pop_front());
        end
`ifdef RR_MEM_ARBITER_GRANT_CNT_EN
        check("grant_cnt", 64'(grant_cnt), 64'(m_cnt));
`endif
    end

    task automatic cyc(input logic [N-1:0] v, input logic r);
        @(posedge clk);
        #1;
        req_valid = v;
        mem_ready = r;
    endtask

    task automatic do_reset();
        reset = 1;
        q.delete();
        m_full = 0;
        m_ptr = 0;
        m_cnt = 0;
        #1;
        check("rst_mem_valid", 64'(mem_valid), 64'(0));
        check("rst_req_ready", 64'(req_ready), 64'(0));
        check("rst_mem_bits", 64'(mem_bits), 64'(0));
        check("rst_mem_id", 64'(mem_id), 64'(0));
`ifdef RR_MEM_ARBITER_GRANT_CNT_EN
        check("rst_grant_cnt", 64'(grant_cnt), 64'(0));
`endif
        repeat (2) @(posedge clk);
        #3 reset = 0;
    endtask

    initial begin : main
        logic [N-1:0] g;
        for (int i = 0; i < N; i++) req_bits[i*DW +: DW] = $urandom;
        #2 do_reset();
        repeat (5) cyc('0, 1'($urandom_range(0, 1)));
        req_bits[2*DW +: DW] = 32'hDEADBEEF;
        cyc(4'b0100, 1);
        cyc(4'b0000, 1);
        repeat (6) cyc(4'b1111, 1);
        cyc(4'b0000, 1);
        cyc(4'b0010, 1);
        repeat (4) cyc(4'b1111, 0);
        cyc(4'b1111, 1);
        cyc(4'b0000, 1);
        cyc(4'b0100, 1);
        cyc(4'b0011, 1);
        cyc(4'b0010, 1);
        cyc(4'b0000, 1);
        cyc(4'b0001, 1);
        cyc(4'b0000, 0);
        #2 do_reset();
        cyc(4'b1111, 1);
        cyc(4'b0000, 1);
        repeat (3000) begin
            @(negedge clk);
            g = req_valid & req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++)
                if (g[i] || !req_valid[i]) begin
                    req_valid[i] = $urandom_range(0, 2) != 0;
                    req_bits[i*DW +: DW] = $urandom;
                end
            mem_ready = $urandom_range(0, 3) != 0;
        end
        repeat (3) cyc('0, 1);
        @(negedge clk);
        #2 check("drained", 64'(q.size()), 64'(0));
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
